y86_pipe_ctrl: RTL and testbench

- Pipeline control and forwarding unit for the five-stage Y86 core (fetch/decode/execute/memory/writeback).
- Adds the hazard handling the current core lacks: data forwarding into decode, load/use stall, mispredicted-branch squash, ret handling and exception freeze.
- Parametrised in data width, register-ID width and counter width; sits beside the stage registers and drives their stall/bubble inputs.
- Holds a run-state machine with a stall watchdog and optional performance counters.

---
 rtl/y86_pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_y86_pipe_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/y86_pipe_ctrl.sv
// y86_pipe_ctrl: Y86 five-stage hazard control, operand forwarding, run-state FSM with stall watchdog.
// Define PIPE_PERF_CNT_EN to add saturating cycle/stall/bubble performance counters.
module y86_pipe_ctrl #(
  parameter int WORD_W   = 32,
  parameter int REG_AW   = 4,
  parameter int WDOG_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        d_icode,
  input  logic [REG_AW-1:0] d_srcA,
  input  logic [REG_AW-1:0] d_srcB,
  input  logic [WORD_W-1:0] d_rvalA,
  input  logic [WORD_W-1:0] d_rvalB,
  input  logic [WORD_W-1:0] d_valP,
  input  logic [3:0]        e_icode,
  input  logic [REG_AW-1:0] e_dstE,
  input  logic [REG_AW-1:0] e_dstM,
  input  logic [WORD_W-1:0] e_valE,
  input  logic              e_cnd,
  input  logic [3:0]        m_icode,
  input  logic [REG_AW-1:0] m_dstE,
  input  logic [REG_AW-1:0] m_dstM,
  input  logic [WORD_W-1:0] m_valE,
  input  logic [WORD_W-1:0] m_valM,
  input  logic [2:0]        m_stat,
  input  logic [REG_AW-1:0] w_dstE,
  input  logic [REG_AW-1:0] w_dstM,
  input  logic [WORD_W-1:0] w_valE,
  input  logic [WORD_W-1:0] w_valM,
  input  logic [2:0]        w_stat,
  output logic [WORD_W-1:0] d_valA_o,
  output logic [WORD_W-1:0] d_valB_o,
  output logic              f_stall,
  output logic              d_stall,
  output logic              d_bubble,
  output logic              e_bubble,
  output logic              m_bubble,
  output logic              w_stall,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0]  cyc_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
  output logic [1:0]        state_o,
  output logic              wdog_err_o
);
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [REG_AW-1:0] RNONE = '1;
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic wdog_err_q, wdog_err_d;
  logic run, load_use, ret_pend, mispred, w_exc, exc;
  // Newest producer wins; RNONE sources never match a forwarding path.
  function automatic logic [WORD_W-1:0] fwd(input logic [REG_AW-1:0] src, input logic [WORD_W-1:0] rval);
    return src == RNONE ? rval :
           src == e_dstE ? e_valE :
           src == m_dstM ? m_valM :
           src == m_dstE ? m_valE :
           src == w_dstM ? w_valM :
           src == w_dstE ? w_valE : rval;
  endfunction
  always_comb begin
    d_valA_o = (d_icode == I_CALL || d_icode == I_JXX) ? d_valP : fwd(d_srcA, d_rvalA);
    d_valB_o = fwd(d_srcB, d_rvalB);
    load_use = (e_icode == I_MRMOVL || e_icode == I_POPL) && e_dstM != RNONE &&
               (e_dstM == d_srcA || e_dstM == d_srcB);
    ret_pend = d_icode == I_RET || e_icode == I_RET || m_icode == I_RET;
    mispred  = e_icode == I_JXX && !e_cnd;
    w_exc    = w_stat != S_AOK;
    exc      = m_stat != S_AOK || w_exc;
    run      = state_q == ST_RUN;
    f_stall  = run ? load_use | ret_pend : 1'b1;
    d_stall  = run ? load_use : 1'b1;
    d_bubble = run & (mispred | (ret_pend & !load_use));
    e_bubble = run & (mispred | load_use);
    m_bubble = run ? exc : 1'b1;
    w_stall  = run ? w_exc : 1'b1;
    wdog_d   = !run ? wdog_q : f_stall ? wdog_q + CNT_W'(1) : '0;
    state_d  = !run ? state_q : w_exc ? ST_HALT : wdog_d == CNT_W'(WDOG_MAX) ? ST_ERR : ST_RUN;
    wdog_err_d = state_d == ST_ERR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
    end
  end
  assign state_o    = state_q;
  assign wdog_err_o = wdog_err_q;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d, stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  // Counters only advance in RUN and stick at all-ones.
  always_comb begin
    cyc_cnt_d    = run && ~&cyc_cnt_q ? cyc_cnt_q + CNT_W'(1) : cyc_cnt_q;
    stall_cnt_d  = run && f_stall && ~&stall_cnt_q ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    bubble_cnt_d = run && (d_bubble || e_bubble) && ~&bubble_cnt_q ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      cyc_cnt_q    <= cyc_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign cyc_cnt_o    = cyc_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// tb_y86_pipe_ctrl: scoreboard bench for y86_pipe_ctrl (WDOG_MAX=4); perf checks when PIPE_PERF_CNT_EN is defined.
module tb_y86_pipe_ctrl;
  localparam int W = 32, A = 4, CW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] d_icode, e_icode, m_icode;
  logic [A-1:0] d_srcA, d_srcB, e_dstE, e_dstM, m_dstE, m_dstM, w_dstE, w_dstM;
  logic [W-1:0] d_rvalA, d_rvalB, d_valP, e_valE, m_valE, m_valM, w_valE, w_valM;
  logic e_cnd;
  logic [2:0] m_stat, w_stat;
  logic [W-1:0] d_valA_o, d_valB_o;
  logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, wdog_err_o;
  logic [1:0] state_o;
  logic [72:0] q[$];
  logic [72:0] got, exp;
  int pass_cnt = 0, chk_cnt = 0;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] cyc_cnt_o, stall_cnt_o, bubble_cnt_o;
  logic [3*CW-1:0] pq[$];
  logic [3*CW-1:0] pexp;
`endif
  always #5 clk = ~clk;
  y86_pipe_ctrl #(.WORD_W(W), .REG_AW(A), .WDOG_MAX(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB), .d_valP(d_valP),
    .e_icode(e_icode), .e_dstE(e_dstE), .e_dstM(e_dstM), .e_valE(e_valE), .e_cnd(e_cnd),
    .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM), .m_valE(m_valE), .m_valM(m_valM), .m_stat(m_stat),
    .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM), .w_stat(w_stat),
    .d_valA_o(d_valA_o), .d_valB_o(d_valB_o),
    .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble), .e_bubble(e_bubble),
    .m_bubble(m_bubble), .w_stall(w_stall),
`ifdef PIPE_PERF_CNT_EN
    .cyc_cnt_o(cyc_cnt_o), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o),
`endif
    .state_o(state_o), .wdog_err_o(wdog_err_o)
  );
  assign got = {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, d_valA_o, d_valB_o, state_o, wdog_err_o};
  function automatic logic [72:0] ev(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [1:0] s, input logic e);
    return {c, a, b, s, e};
  endfunction
  task automatic idle();
    d_icode = 4'h1; e_icode = 4'h1; m_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; e_dstE = 4'hF; e_dstM = 4'hF;
    m_dstE = 4'hF; m_dstM = 4'hF; w_dstE = 4'hF; w_dstM = 4'hF;
    d_rvalA = 32'hA0; d_rvalB = 32'hB0; d_valP = 32'hC0;
    e_valE = 0; m_valE = 0; m_valM = 0; w_valE = 0; w_valM = 0;
    e_cnd = 1'b1; m_stat = 3'd1; w_stat = 3'd1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.push_back(ev(6'b000000, 32'hA0, 32'hB0, 2'd0, 1'b0));
    @(negedge clk);
    exp = q.pop_front();
    chk_cnt++;
    if (got !== exp) $display("FAIL reset: got %h expected %h", got, exp); else pass_cnt++;
  endtask
  task automatic test_forward();
    for (int i = 0; i < 7; i++) begin
      step();
      idle();
      case (i)
        0: begin d_srcA = 3; e_dstE = 3; e_valE = 32'h11; m_dstM = 3; m_valM = 32'h22; q.push_back(ev(0, 32'h11, 32'hB0, 0, 0)); end
        1: begin d_srcA = 3; m_dstM = 3; m_valM = 32'h22; q.push_back(ev(0, 32'h22, 32'hB0, 0, 0)); end
        2: begin e_dstE = 4'hF; m_dstM = 4'hF; q.push_back(ev(0, 32'hA0, 32'hB0, 0, 0)); end
        3: begin d_srcB = 4; m_dstE = 4; m_valE = 32'h33; w_dstM = 4; w_valM = 32'h44; w_dstE = 4; w_valE = 32'h55; q.push_back(ev(0, 32'hA0, 32'h33, 0, 0)); end
        4: begin d_srcB = 4; w_dstM = 4; w_valM = 32'h44; w_dstE = 4; w_valE = 32'h55; q.push_back(ev(0, 32'hA0, 32'h44, 0, 0)); end
        5: begin d_srcB = 4; w_dstE = 4; w_valE = 32'h55; q.push_back(ev(0, 32'hA0, 32'h55, 0, 0)); end
        default: begin d_icode = 4'h8; d_srcA = 3; e_dstE = 3; e_valE = 32'h11; q.push_back(ev(0, 32'hC0, 32'hB0, 0, 0)); end
      endcase
      @(negedge clk);
      exp = q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL forward[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
  endtask
  task automatic test_load_use();
    for (int i = 0; i < 2; i++) begin
      step();
      idle();
      e_dstM = 2; d_srcB = 2;
      e_icode = (i == 0) ? 4'h5 : 4'h1;
      q.push_back(ev(i == 0 ? 6'b110100 : 6'b000000, 32'hA0, 32'hB0, 0, 0));
      @(negedge clk);
      exp = q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL load_use[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
  endtask
  task automatic test_mispred_ret();
    for (int i = 0; i < 3; i++) begin
      step();
      idle();
      case (i)
        0: begin e_icode = 4'h7; e_cnd = 1'b0; d_icode = 4'h9; q.push_back(ev(6'b101100, 32'hA0, 32'hB0, 0, 0)); end
        1: begin m_icode = 4'h9; q.push_back(ev(6'b101000, 32'hA0, 32'hB0, 0, 0)); end
        default: begin e_icode = 4'h7; q.push_back(ev(6'b000000, 32'hA0, 32'hB0, 0, 0)); end
      endcase
      @(negedge clk);
      exp = q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL mispred_ret[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
  endtask
  task automatic test_exception();
    for (int i = 0; i < 6; i++) begin
      step();
      idle();
      case (i)
        0: begin m_stat = 3'd3; q.push_back(ev(6'b000010, 32'hA0, 32'hB0, 0, 0)); end
        1: begin w_stat = 3'd2; q.push_back(ev(6'b000011, 32'hA0, 32'hB0, 0, 0)); end
        2: q.push_back(ev(6'b110011, 32'hA0, 32'hB0, 1, 0));
        3: begin e_icode = 4'h5; e_dstM = 2; d_srcB = 2; q.push_back(ev(6'b110011, 32'hA0, 32'hB0, 1, 0)); end
        4: begin rst = 1'b1; q.push_back(ev(6'b110011, 32'hA0, 32'hB0, 1, 0)); end
        default: begin rst = 1'b0; q.push_back(ev(6'b000000, 32'hA0, 32'hB0, 0, 0)); end
      endcase
      @(negedge clk);
      exp = q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL exception[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
  endtask
  task automatic test_watchdog();
    for (int i = 0; i < 10; i++) begin
      step();
      idle();
      d_icode = 4'h9;
      if (i == 5) rst = 1'b1;
      if (i == 6) rst = 1'b0;
      if (i == 9) d_icode = 4'h1;
      if (i == 4 || i == 5) q.push_back(ev(6'b110011, 32'hA0, 32'hB0, 2, 1));
      else if (i == 9) q.push_back(ev(6'b000000, 32'hA0, 32'hB0, 0, 0));
      else q.push_back(ev(6'b101000, 32'hA0, 32'hB0, 0, 0));
      @(negedge clk);
      exp = q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL watchdog[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
  endtask
`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    step();
    idle();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      rst = 1'b0;
      idle();
      if (i == 2 || i == 5 || i == 7) begin e_icode = 4'h5; e_dstM = 2; d_srcA = 2; end
    end
    pq.push_back({CW'(10), CW'(3), CW'(3)});
    step();
    idle();
    w_stat = 3'd2;
    @(negedge clk);
    pexp = pq.pop_front();
    chk_cnt++;
    if ({cyc_cnt_o, stall_cnt_o, bubble_cnt_o} !== pexp)
      $display("FAIL perf_run: got %h expected %h", {cyc_cnt_o, stall_cnt_o, bubble_cnt_o}, pexp);
    else pass_cnt++;
    pq.push_back({CW'(11), CW'(3), CW'(3)});
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    pexp = pq.pop_front();
    chk_cnt++;
    if ({cyc_cnt_o, stall_cnt_o, bubble_cnt_o} !== pexp || state_o !== 2'd1)
      $display("FAIL perf_frozen: got %h state %0d expected %h state 1", {cyc_cnt_o, stall_cnt_o, bubble_cnt_o}, state_o, pexp);
    else pass_cnt++;
  endtask
`endif
  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mispred_ret();
    test_exception();
    test_watchdog();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
